// File: rtl/gcu_dep_tracker_mc_if.sv
// Bus bundle for the GCU dependency tracker: init, done scatter,
// ready pop, debug query and sticky error status.
interface gcu_dep_tracker_mc_if #(
  parameter int NODE_ID_W = 4,
  parameter int CNT_W     = 8,
  parameter int NUM_DONE  = 2
);
  logic                          clr_all;
  logic                          init_valid;
  logic [NODE_ID_W-1:0]          init_node_id;
  logic [CNT_W-1:0]              init_count;
  logic [NUM_DONE-1:0]           done_valid;
  logic [NUM_DONE*NODE_ID_W-1:0] done_parent_id;
  logic                          rdy_valid;
  logic [NODE_ID_W-1:0]          rdy_node_id;
  logic                          rdy_pop;
  logic                          query_valid;
  logic [NODE_ID_W-1:0]          query_node_id;
  logic                          query_ready;
  logic [CNT_W-1:0]              query_count;
  logic                          err_underflow;
  logic                          err_range;

  modport master (
    output clr_all, init_valid, init_node_id, init_count,
    output done_valid, done_parent_id, rdy_pop,
    output query_valid, query_node_id,
    input  rdy_valid, rdy_node_id, query_ready, query_count,
    input  err_underflow, err_range
  );

  modport slave (
    input  clr_all, init_valid, init_node_id, init_count,
    input  done_valid, done_parent_id, rdy_pop,
    input  query_valid, query_node_id,
    output rdy_valid, rdy_node_id, query_ready, query_count,
    output err_underflow, err_range
  );
endinterface

// File: rtl/gcu_dep_tracker_mc.sv
// Per-node pending-children counters with multi-channel done
// decrements and a ready bitmap drained lowest-index first.
module gcu_dep_tracker_mc #(
  parameter int NODE_ID_W = 4,
  parameter int MAX_NODES = 16,
  parameter int CNT_W     = 8,
  parameter int NUM_DONE  = 2
) (
  input logic clk,
  input logic rst_n,
  gcu_dep_tracker_mc_if.slave bus
);

  localparam int DW = CNT_W + 1;
  localparam logic [NODE_ID_W:0] MAX_L = (NODE_ID_W+1)'(MAX_NODES);

  logic [MAX_NODES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [MAX_NODES-1:0]            armed_q, armed_d;
  logic [MAX_NODES-1:0]            rdy_q, rdy_d;
  logic                            qry_rdy_q, qry_rdy_d;
  logic [CNT_W-1:0]                qry_cnt_q, qry_cnt_d;
  logic                            err_uf_q, err_uf_d;
  logic                            err_rg_q, err_rg_d;

  logic [MAX_NODES-1:0][DW-1:0]    dec;
  logic [NODE_ID_W-1:0]            ch_id;
  logic [NODE_ID_W-1:0]            rdy_id;
  logic                            rdy_vld;
  logic                            init_ok;
  logic                            qry_ok;

  function automatic logic in_range(input logic [NODE_ID_W-1:0] id);
    return {1'b0, id} < MAX_L;
  endfunction

  always_comb begin
    rdy_id = '0;
    for (int n = MAX_NODES - 1; n >= 0; n--) begin
      if (rdy_q[n]) rdy_id = NODE_ID_W'(n);
    end
  end

  assign rdy_vld = |rdy_q;
  assign init_ok = bus.init_valid && in_range(bus.init_node_id);
  assign qry_ok  = bus.query_valid && in_range(bus.query_node_id);

  always_comb begin
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    rdy_d     = rdy_q;
    err_uf_d  = err_uf_q;
    err_rg_d  = err_rg_q;
    qry_rdy_d = 1'b0;
    qry_cnt_d = '0;
    dec       = '0;
    ch_id     = '0;

    for (int k = 0; k < NUM_DONE; k++) begin
      ch_id = bus.done_parent_id[k*NODE_ID_W +: NODE_ID_W];
      if (bus.done_valid[k]) begin
        if (!in_range(ch_id)) begin
          err_rg_d = 1'b1;
        end else begin
          for (int n = 0; n < MAX_NODES; n++) begin
            if (ch_id == NODE_ID_W'(n))
              dec[n] = dec[n] + DW'(1);
          end
        end
      end
    end

    if (bus.init_valid && !init_ok) err_rg_d = 1'b1;

    // pop clears first so a same-cycle set on that node wins
    if (bus.rdy_pop && rdy_vld) begin
      for (int n = 0; n < MAX_NODES; n++) begin
        if (rdy_id == NODE_ID_W'(n)) rdy_d[n] = 1'b0;
      end
    end

    for (int n = 0; n < MAX_NODES; n++) begin
      if (init_ok && bus.init_node_id == NODE_ID_W'(n)) begin
        cnt_d[n]   = bus.init_count;
        armed_d[n] = 1'b1;
        rdy_d[n]   = (bus.init_count == '0);
      end else if (dec[n] != '0) begin
        if (!armed_q[n]) begin
          err_uf_d = 1'b1;
        end else begin
          if (dec[n] > {1'b0, cnt_q[n]}) begin
            cnt_d[n] = '0;
            err_uf_d = 1'b1;
          end else begin
            cnt_d[n] = cnt_q[n] - dec[n][CNT_W-1:0];
          end
          if (cnt_q[n] != '0 && cnt_d[n] == '0)
            rdy_d[n] = 1'b1;
        end
      end
    end

    if (qry_ok) begin
      for (int n = 0; n < MAX_NODES; n++) begin
        if (bus.query_node_id == NODE_ID_W'(n)) begin
          qry_rdy_d = armed_q[n] && (cnt_q[n] == '0);
          qry_cnt_d = cnt_q[n];
        end
      end
    end

    if (bus.clr_all) begin
      cnt_d     = '0;
      armed_d   = '0;
      rdy_d     = '0;
      err_uf_d  = 1'b0;
      err_rg_d  = 1'b0;
      qry_rdy_d = 1'b0;
      qry_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      armed_q   <= '0;
      rdy_q     <= '0;
      qry_rdy_q <= 1'b0;
      qry_cnt_q <= '0;
      err_uf_q  <= 1'b0;
      err_rg_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      rdy_q     <= rdy_d;
      qry_rdy_q <= qry_rdy_d;
      qry_cnt_q <= qry_cnt_d;
      err_uf_q  <= err_uf_d;
      err_rg_q  <= err_rg_d;
    end
  end

  assign bus.rdy_valid     = rdy_vld;
  assign bus.rdy_node_id   = rdy_id;
  assign bus.query_ready   = qry_rdy_q;
  assign bus.query_count   = qry_cnt_q;
  assign bus.err_underflow = err_uf_q;
  assign bus.err_range     = err_rg_q;

endmodule

// File: tb/tb_gcu_dep_tracker_mc.sv
// Scoreboard bench for gcu_dep_tracker_mc with MAX_NODES=12 so
// out-of-range ids are reachable.
module tb_gcu_dep_tracker_mc;

  localparam int NW = 4;
  localparam int MN = 12;
  localparam int CW = 8;
  localparam int ND = 2;

  logic clk;
  logic rst_n;

  gcu_dep_tracker_mc_if #(.NODE_ID_W(NW), .CNT_W(CW), .NUM_DONE(ND)) bus();

  gcu_dep_tracker_mc #(
    .NODE_ID_W(NW), .MAX_NODES(MN), .CNT_W(CW), .NUM_DONE(ND)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_err;

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int unsigned exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(int unsigned obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_underrun: got 0x%0h expected none", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr_all        = 1'b0;
    bus.init_valid     = 1'b0;
    bus.init_node_id   = '0;
    bus.init_count     = '0;
    bus.done_valid     = '0;
    bus.done_parent_id = '0;
    bus.rdy_pop        = 1'b0;
    bus.query_valid    = 1'b0;
    bus.query_node_id  = '0;
  endtask

  task automatic set_init(int id, int cnt);
    bus.init_valid   = 1'b1;
    bus.init_node_id = NW'(id);
    bus.init_count   = CW'(cnt);
  endtask

  task automatic set_done(int ch, int id);
    bus.done_valid[ch] = 1'b1;
    bus.done_parent_id[ch*NW +: NW] = NW'(id);
  endtask

  task automatic query(string tag, int id, bit r, int cnt);
    bus.query_valid   = 1'b1;
    bus.query_node_id = NW'(id);
    push(tag, (int'(r) << CW) | cnt);
    tick();
    idle();
    pop_chk({23'd0, bus.query_ready, bus.query_count});
  endtask

  task automatic expect_rdy(string tag, bit v, int id);
    push(tag, (int'(v) << NW) | id);
    pop_chk({27'd0, bus.rdy_valid, bus.rdy_node_id});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    expect_rdy("reset_rdy", 0, 0);
    chk("reset_uf", bus.err_underflow, 0);
    chk("reset_rg", bus.err_range, 0);
    query("reset_q3", 3, 0, 0);

    set_init(5, 3); tick(); idle();
    set_done(0, 5); set_done(1, 5); tick(); idle();
    expect_rdy("n5_cnt1_rdy", 0, 0);
    query("n5_cnt1_q", 5, 0, 1);
    set_done(0, 5); tick(); idle();
    expect_rdy("n5_ready", 1, 5);
    query("n5_q0", 5, 1, 0);
    bus.rdy_pop = 1'b1; tick(); idle();
    expect_rdy("n5_popped", 0, 0);

    set_init(2, 1); tick(); idle();
    set_init(9, 1); tick(); idle();
    set_done(0, 9); set_done(1, 2); tick(); idle();
    expect_rdy("pair_first", 1, 2);
    bus.rdy_pop = 1'b1; tick(); idle();
    expect_rdy("pair_second", 1, 9);
    bus.rdy_pop = 1'b1; tick(); idle();
    expect_rdy("pair_empty", 0, 0);

    set_init(4, 1); tick(); idle();
    set_done(0, 4); set_done(1, 4); tick(); idle();
    chk("clamp_uf", bus.err_underflow, 1);
    expect_rdy("clamp_rdy", 1, 4);
    query("clamp_q4", 4, 1, 0);
    bus.clr_all = 1'b1; tick(); idle();
    chk("clr_uf", bus.err_underflow, 0);
    expect_rdy("clr_rdy", 0, 0);
    query("clr_q4", 4, 0, 0);

    set_init(6, 2); set_done(0, 6); tick(); idle();
    query("init_wins_q6", 6, 0, 2);
    chk("init_wins_uf", bus.err_underflow, 0);
    set_init(7, 0); tick(); idle();
    expect_rdy("n7_ready", 1, 7);
    set_init(7, 0); bus.rdy_pop = 1'b1; tick(); idle();
    expect_rdy("set_wins_pop", 1, 7);
    bus.rdy_pop = 1'b1; tick(); idle();
    expect_rdy("n7_popped", 0, 0);

    set_init(6, 5);
    query("q_old_val", 6, 0, 2);
    query("q_new_val", 6, 0, 5);

    chk("pre_rg", bus.err_range, 0);
    set_done(0, 14); tick(); idle();
    chk("range_done", bus.err_range, 1);
    chk("range_no_uf", bus.err_underflow, 0);
    query("range_q6", 6, 0, 5);
    query("range_q13", 13, 0, 0);
    expect_rdy("range_rdy", 0, 0);

    set_done(1, 10); tick(); idle();
    chk("unarmed_uf", bus.err_underflow, 1);
    query("unarmed_q10", 10, 0, 0);

    set_init(3, 0); tick(); idle();
    expect_rdy("pre_arst", 1, 3);
    rst_n = 1'b0;
    #2;
    expect_rdy("arst_rdy", 0, 0);
    chk("arst_rg", bus.err_range, 0);
    chk("arst_uf", bus.err_underflow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    query("arst_q6", 6, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
